fp_align_ctrl: RTL and testbench
================================

// Module: fp_align_ctrl
// PURPOSE
//   Sequences floating-point add/sub operand alignment around the exponent-difference datapath.
//   - Accepts two unpacked operands.
//   - Orders them by exponent and computes the shift count (clamped).
//   - Right-shifts the smaller mantissa one bit per cycle into guard/round positions.
//   - Presents the aligned pair to the mantissa adder.
//   Sits between the operand unpack stage and the mantissa add/normalise stage.
// PARAMETERS
//   EXP_W      11        exponent width (unsigned, biased)
//   MAN_W      53        mantissa width incl. hidden bit
//   MAX_SHIFT  MAN_W+2   shift-count clamp; align register is MAN_W+2 bits (guard+round)
// PORTS
//   clk        in   1          single clock, rising edge
//   reset      in   1          synchronous, active-high
//   in_valid   in   1          operand pair valid
//   in_ready   out  1          block can accept a pair
//   exp_a      in   EXP_W      operand A exponent
//   man_a      in   MAN_W      operand A mantissa
//   exp_b      in   EXP_W      operand B exponent
//   man_b      in   MAN_W      operand B mantissa
//   out_valid  out  1          aligned result valid
//   out_ready  in   1          downstream accepts result
//   exp_out    out  EXP_W      larger exponent
//   man_big    out  MAN_W+2    larger-exponent mantissa, {man,2'b00}
//   man_small  out  MAN_W+2    aligned smaller mantissa, {man,2'b00}>>shift
//   sticky     out  1          OR of all bits shifted out of man_small
//   swapped    out  1          1 = B had the larger exponent (B is in man_big)
// BEHAVIOUR
//   - FSM states: IDLE -> CMP -> SHIFT -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid&&in_ready, register the operands and go to CMP.
//   - CMP (1 cycle): slt = exp_a<exp_b (unsigned).
//     - swapped=slt; exp_out = max exponent.
//     - man_big / man_small loaded as {man,2'b00} of larger / smaller operand.
//     - cnt = min(|exp_a-exp_b|, MAX_SHIFT); sticky=0.
//     - cnt==0 -> DONE, else -> SHIFT.
//   - SHIFT: each cycle man_small >>= 1; sticky |= shifted-out LSB; cnt--.
//     Go to DONE when cnt reaches 0 (after the shift).
//   - DONE: out_valid=1; outputs held stable until out_ready.
//     On out_valid&&out_ready -> IDLE; in_ready=1 the next cycle (no same-cycle reaccept).
//   - Latency (accept edge to first out_valid cycle): 2 + cnt cycles.
//     Minimum 2 (equal exponents); maximum 2+MAX_SHIFT.
//   - Equal exponents: swapped=0; A is treated as larger.
//   - Clamp: |diff|>MAX_SHIFT shifts exactly MAX_SHIFT times, so man_small=0 and
//     sticky = OR of all bits of {man_small,2'b00}.
//   - in_ready=0 in every state except IDLE; in_valid is ignored outside IDLE.
//   - Reset (any state, incl. mid-SHIFT): next state IDLE.
//     All registered outputs go to 0 (exp_out, man_big, man_small, sticky, swapped, out_valid).
//     in_ready=0 while reset is high, 1 from the first cycle after reset drops.
//   - Diff magnitude is computed EXP_W+1 wide; no wrap for any exponent pair (0..2^EXP_W-1).
// CONFIGURATION
//   FP_ALIGN_STICKY_EN defined:
//     - sticky accumulates as above.
//     - Adds a 1-bit register.
//   FP_ALIGN_STICKY_EN undefined:
//     - sticky is tied to 0.
//     - No sticky register; shifted-out bits are discarded.
//     - All other outputs and timing are identical.
// TESTING
//   1. A=(200,man X), B=(180,man Y) -> swapped=0, exp_out=200, 20 shifts, out_valid 22 cycles after accept.
//   2. A=127, B=200 -> diff 73 clamps to 55; swapped=1, exp_out=200, man_small=0, latency 57.
//   3. A=200, B=200 -> swapped=0, man_small={man_b,2'b00}, sticky=0, latency 2.
//   4. A=30, B=240, man_a=53'h1 -> 55 shifts, man_small=0; sticky=1 with FP_ALIGN_STICKY_EN, 0 without.
//   5. out_ready low 10 cycles in DONE -> all outputs stable, in_ready=0; one-cycle out_ready -> IDLE next.
//   6. reset pulsed during SHIFT of case 1 -> all outputs 0 next cycle; a new pair is accepted afterwards
//      and completes with correct results.

Source files
------------

// File: rtl/fp_align_ctrl.sv
// Operand alignment sequencer for FP add/sub: orders operands by exponent, then right-shifts
// the smaller mantissa one bit per cycle. Optional sticky tracking via FP_ALIGN_STICKY_EN.
module fp_align_ctrl #(
    parameter int unsigned EXP_W     = 11,
    parameter int unsigned MAN_W     = 53,
    parameter int unsigned MAX_SHIFT = MAN_W + 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   exp_a,
    input  logic [MAN_W-1:0]   man_a,
    input  logic [EXP_W-1:0]   exp_b,
    input  logic [MAN_W-1:0]   man_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   exp_out,
    output logic [MAN_W+1:0]   man_big,
    output logic [MAN_W+1:0]   man_small,
    output logic               sticky,
    output logic               swapped
);

    localparam int unsigned CNT_W = $clog2(MAX_SHIFT + 1);
    localparam logic [EXP_W:0] MAX_SHIFT_W = (EXP_W + 1)'(MAX_SHIFT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMP   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [EXP_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic [MAN_W-1:0] man_a_q, man_a_d, man_b_q, man_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EXP_W-1:0] exp_out_q, exp_out_d;
    logic [MAN_W+1:0] man_big_q, man_big_d;
    logic [MAN_W+1:0] man_small_q, man_small_d;
    logic             swapped_q, swapped_d;
    logic             out_valid_q, out_valid_d;
`ifdef FP_ALIGN_STICKY_EN
    logic             sticky_q, sticky_d;
`endif

    logic             slt;
    logic [EXP_W:0]   diff;
    logic [EXP_W:0]   diff_clamped;

    // Extra bit on the difference keeps any exponent pair from wrapping.
    assign slt          = exp_a_q < exp_b_q;
    assign diff         = slt ? ({1'b0, exp_b_q} - {1'b0, exp_a_q})
                              : ({1'b0, exp_a_q} - {1'b0, exp_b_q});
    assign diff_clamped = (diff > MAX_SHIFT_W) ? MAX_SHIFT_W : diff;

    always_comb begin
        state_d     = state_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        man_a_d     = man_a_q;
        man_b_d     = man_b_q;
        cnt_d       = cnt_q;
        exp_out_d   = exp_out_q;
        man_big_d   = man_big_q;
        man_small_d = man_small_q;
        swapped_d   = swapped_q;
        out_valid_d = out_valid_q;
`ifdef FP_ALIGN_STICKY_EN
        sticky_d    = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_a_d = exp_a;
                    exp_b_d = exp_b;
                    man_a_d = man_a;
                    man_b_d = man_b;
                    state_d = CMP;
                end
            end
            CMP: begin
                swapped_d   = slt;
                exp_out_d   = slt ? exp_b_q : exp_a_q;
                man_big_d   = slt ? {man_b_q, 2'b00} : {man_a_q, 2'b00};
                man_small_d = slt ? {man_a_q, 2'b00} : {man_b_q, 2'b00};
                cnt_d       = CNT_W'(diff_clamped);
`ifdef FP_ALIGN_STICKY_EN
                sticky_d    = 1'b0;
`endif
                if (diff == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                man_small_d = man_small_q >> 1;
`ifdef FP_ALIGN_STICKY_EN
                sticky_d    = sticky_q | man_small_q[0];
`endif
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            man_a_q     <= '0;
            man_b_q     <= '0;
            cnt_q       <= '0;
            exp_out_q   <= '0;
            man_big_q   <= '0;
            man_small_q <= '0;
            swapped_q   <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            exp_a_q     <= exp_a_d;
            exp_b_q     <= exp_b_d;
            man_a_q     <= man_a_d;
            man_b_q     <= man_b_d;
            cnt_q       <= cnt_d;
            exp_out_q   <= exp_out_d;
            man_big_q   <= man_big_d;
            man_small_q <= man_small_d;
            swapped_q   <= swapped_d;
            out_valid_q <= out_valid_d;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q    <= sticky_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign exp_out   = exp_out_q;
    assign man_big   = man_big_q;
    assign man_small = man_small_q;
    assign swapped   = swapped_q;
`ifdef FP_ALIGN_STICKY_EN
    assign sticky    = sticky_q;
`else
    assign sticky    = 1'b0;
`endif

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Self-checking bench for fp_align_ctrl: per-cycle compare against a transaction-level model,
// plus directed vectors with literal expectations.
module tb_fp_align_ctrl;

    localparam int EXP_W = 11;
    localparam int MAN_W = 53;
`ifdef FP_ALIGN_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [EXP_W-1:0]   exp_a = '0, exp_b = '0;
    logic [MAN_W-1:0]   man_a = '0, man_b = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [EXP_W-1:0]   exp_out;
    logic [MAN_W+1:0]   man_big, man_small;
    logic               sticky, swapped;

    fp_align_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_a     (exp_a),
        .man_a     (man_a),
        .exp_b     (exp_b),
        .man_b     (man_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .man_big   (man_big),
        .man_small (man_small),
        .sticky    (sticky),
        .swapped   (swapped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model state.
    bit               busy = 1'b0;
    bit               clr = 1'b1;
    int               age = 0;
    int               m_lat = 0;
    logic [EXP_W-1:0] m_exp;
    logic [54:0]      m_big, m_small;
    logic             m_sticky, m_swapped;

    task automatic model(input int ea, input int eb, input logic [52:0] ma, input logic [52:0] mb);
        int d, sh;
        logic [54:0] full, mask;
        m_swapped = (ea < eb);
        m_exp     = m_swapped ? EXP_W'(eb) : EXP_W'(ea);
        m_big     = m_swapped ? {mb, 2'b00} : {ma, 2'b00};
        full      = m_swapped ? {ma, 2'b00} : {mb, 2'b00};
        d         = (ea > eb) ? ea - eb : eb - ea;
        sh        = (d > 55) ? 55 : d;
        m_small   = full >> sh;
        mask      = (55'(1) << sh) - 55'(1);
        m_sticky  = STICKY_ON ? |(full & mask) : 1'b0;
        m_lat     = 2 + sh;
    endtask

    always @(negedge clk) begin
        bit exp_rdy, exp_ov;
        if (busy) age++;
        exp_rdy = !reset && !busy;
        exp_ov  = busy && (age >= m_lat);
        chk("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
        chk("out_valid", {127'd0, out_valid}, {127'd0, exp_ov});
        if (exp_ov) begin
            chk("exp_out", 128'(exp_out), 128'(m_exp));
            chk("man_big", 128'(man_big), 128'(m_big));
            chk("man_small", 128'(man_small), 128'(m_small));
            chk("sticky", 128'(sticky), 128'(m_sticky));
            chk("swapped", 128'(swapped), 128'(m_swapped));
        end
        if (clr && (!busy || age < 2)) begin
            chk("clr_exp_out", 128'(exp_out), 128'd0);
            chk("clr_man_big", 128'(man_big), 128'd0);
            chk("clr_man_small", 128'(man_small), 128'd0);
            chk("clr_flags", {125'd0, sticky, swapped, out_valid}, 128'd0);
        end
        if (reset) begin
            busy = 1'b0;
            clr  = 1'b1;
        end else if (!busy && in_valid) begin
            busy = 1'b1;
            age  = 0;
            model(int'(exp_a), int'(exp_b), man_a, man_b);
        end else if (exp_ov && out_ready) begin
            busy = 1'b0;
            clr  = 1'b0;
        end
    end

    task automatic accept(input int ea, input logic [52:0] ma, input int eb, input logic [52:0] mb);
        bit ok = 1'b0;
        @(posedge clk); #1;
        exp_a = EXP_W'(ea); man_a = ma; exp_b = EXP_W'(eb); man_b = mb;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        bit ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) chk("out_valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic release_out();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    localparam logic [52:0] MX = 53'h1F_ABCD_1234_5678;
    localparam logic [52:0] MY = 53'h1A_5555_0000_0F0F;

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: diff 20, A larger
        accept(200, MX, 180, MY);
        wait_out(lat);
        chk("t1_latency", 128'(lat), 128'd22);
        chk("t1_exp_out", 128'(exp_out), 128'd200);
        chk("t1_swapped", 128'(swapped), 128'd0);
        chk("t1_man_big", 128'(man_big), 128'({MX, 2'b00}));
        release_out();

        // 2: diff 73 clamps to 55, B larger
        accept(127, MX, 200, MY);
        wait_out(lat);
        chk("t2_latency", 128'(lat), 128'd57);
        chk("t2_exp_out", 128'(exp_out), 128'd200);
        chk("t2_swapped", 128'(swapped), 128'd1);
        chk("t2_man_small", 128'(man_small), 128'd0);
        release_out();

        // 3: equal exponents
        accept(200, MX, 200, MY);
        wait_out(lat);
        chk("t3_latency", 128'(lat), 128'd2);
        chk("t3_swapped", 128'(swapped), 128'd0);
        chk("t3_man_small", 128'(man_small), 128'({MY, 2'b00}));
        chk("t3_sticky", 128'(sticky), 128'd0);
        release_out();

        // 4: lone LSB shifted all the way out
        accept(30, 53'h1, 240, MY);
        wait_out(lat);
        chk("t4_latency", 128'(lat), 128'd57);
        chk("t4_man_small", 128'(man_small), 128'd0);
        chk("t4_sticky", 128'(sticky), 128'(STICKY_ON));
        release_out();

        // 5: downstream stalls 10 cycles in DONE
        accept(200, MX, 180, MY);
        wait_out(lat);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_in_ready_stalled", 128'(in_ready), 128'd0);
        release_out();
        @(negedge clk);
        chk("t5_in_ready_after", 128'(in_ready), 128'd1);

        // 6: reset mid-SHIFT, then a clean transaction
        accept(200, MX, 180, MY);
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_exp_out_zero", 128'(exp_out), 128'd0);
        chk("t6_man_small_zero", 128'(man_small), 128'd0);
        chk("t6_out_valid_zero", 128'(out_valid), 128'd0);
        accept(200, MX, 180, MY);
        wait_out(lat);
        chk("t6_latency", 128'(lat), 128'd22);
        release_out();

        // Extremes: full exponent range and a single-bit difference
        accept(0, MX, 2047, MY);
        wait_out(lat);
        chk("ext_latency", 128'(lat), 128'd57);
        chk("ext_exp_out", 128'(exp_out), 128'd2047);
        release_out();
        accept(1000, MY, 999, MX);
        wait_out(lat);
        chk("d1_latency", 128'(lat), 128'd3);
        chk("d1_man_small", 128'(man_small), 128'({1'b0, MX, 1'b0}));
        release_out();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
